// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SRL/SRA/SLL/ROR barrel shifter, one registered mux stage per amount bit,
// valid/ready on both sides with a whole-pipe stall and a sideband tag.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   load,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);
  logic [WIDTH-1:0] d_q [SHW];
  logic [WIDTH-1:0] pd  [SHW];
  logic [WIDTH-1:0] nd  [SHW];
  logic [SHW-1:0]   l_q [SHW];
  logic [SHW-1:0]   pl  [SHW];
  logic [1:0]       m_q [SHW];
  logic [1:0]       pm  [SHW];
  logic [TAG_W-1:0] t_q [SHW];
  logic [TAG_W-1:0] pt  [SHW];
  logic             v_q [SHW];
  logic             pv  [SHW];
  logic             s_q [SHW];
  logic             ps  [SHW];
  logic             z_q;
  logic             stall;

  // The upper half of the double-width word supplies the fill: zeros, the sign, or the operand itself.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic sg,
                                            input logic [1:0] m, input int n);
    logic [2*WIDTH-1:0] w;
    w = {(m == 2'b11) ? d : {WIDTH{(m == 2'b01) & sg}}, d} >> n;
    return (m == 2'b10) ? d << n : w[WIDTH-1:0];
  endfunction

  assign stall     = v_q[SHW-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[SHW-1];
  assign out       = d_q[SHW-1];
  assign out_tag   = t_q[SHW-1];
  assign out_zero  = z_q;

  always_comb begin
    pd[0] = In;
    pl[0] = load;
    pm[0] = mode;
    pt[0] = in_tag;
    pv[0] = in_valid;
    ps[0] = In[WIDTH-1];
    for (int s = 1; s < SHW; s++) begin
      pd[s] = d_q[s-1];
      pl[s] = l_q[s-1];
      pm[s] = m_q[s-1];
      pt[s] = t_q[s-1];
      pv[s] = v_q[s-1];
      ps[s] = s_q[s-1];
    end
    for (int s = 0; s < SHW; s++)
      nd[s] = pl[s][SHW-1-s] ? step(pd[s], ps[s], pm[s], 1 << (SHW-1-s)) : pd[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '{default: '0};
      l_q <= '{default: '0};
      m_q <= '{default: '0};
      t_q <= '{default: '0};
      v_q <= '{default: 1'b0};
      s_q <= '{default: 1'b0};
      z_q <= 1'b0;
    end else if (!stall) begin
      d_q <= nd;
      l_q <= pl;
      m_q <= pm;
      t_q <= pt;
      v_q <= pv;
      s_q <= ps;
      z_q <= nd[SHW-1] == '0;
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and random checks of 32-bit and 8-bit shifter instances
// against an arithmetic reference model and per-instance in-order scoreboards.
module tb_pipelined_barrel_shifter;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0;

  logic v32 = 0, r32, or32 = 1, ov32, oz32;
  logic [31:0] d32 = 0, o32;
  logic [4:0] l32 = 0;
  logic [1:0] m32 = 0;
  logic [3:0] t32 = 0, ot32;

  logic v8 = 0, r8, or8 = 1, ov8, oz8;
  logic [7:0] d8 = 0, o8;
  logic [2:0] l8 = 0;
  logic [1:0] m8 = 0;
  logic [3:0] t8 = 0, ot8;

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .In(d32), .load(l32), .mode(m32),
    .in_tag(t32), .out_valid(ov32), .out_ready(or32), .out(o32), .out_tag(ot32), .out_zero(oz32));

  pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .In(d8), .load(l8), .mode(m8),
    .in_tag(t8), .out_valid(ov8), .out_ready(or8), .out(o8), .out_tag(ot8), .out_zero(oz8));

  int n_chk = 0, n_fail = 0;
  int acc32 = 0, done32 = 0, acc8 = 0, done8 = 0;
  logic la32 = 0, la8 = 0;
  logic [35:0] q32[$];
  logic [35:0] q8[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-amount shifts on a 64-bit word, sign pre-extended above bit w-1 for SRA.
  function automatic logic [31:0] ref_shift(input int w, input logic [31:0] x, input int k,
                                            input logic [1:0] m);
    logic [63:0] mask, v, r;
    mask = (64'd1 << w) - 64'd1;
    v = {32'd0, x} & mask;
    case (m)
      2'd0: r = v >> k;
      2'd1: r = (v | (v[w-1] ? ~mask : 64'd0)) >> k;
      2'd2: r = v << k;
      default: r = (v >> k) | (v << (w - k));
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick(input int w);
    int r;
    logic [63:0] mask;
    r = int'($urandom % 5);
    mask = (64'd1 << w) - 64'd1;
    return r == 0 ? 32'd0 : r == 1 ? mask[31:0] : r == 2 ? 32'd1 << (w - 1) : $urandom;
  endfunction

  task automatic tick();
    logic [35:0] e;
    @(negedge clk);
    la32 = v32 && r32;
    la8 = v8 && r8;
    if (la32) begin
      q32.push_back({t32, ref_shift(32, d32, int'(l32), m32)});
      acc32++;
    end
    if (la8) begin
      q8.push_back({t8, ref_shift(8, {24'd0, d8}, int'(l8), m8)});
      acc8++;
    end
    if (ov32 && or32) begin
      done32++;
      if (q32.size() == 0) chk("extra32", 32'(ov32), 32'd0);
      else begin
        e = q32.pop_front();
        chk("out32", o32, e[31:0]);
        chk("tag32", 32'(ot32), 32'(e[35:32]));
        chk("zero32", 32'(oz32), 32'(e[31:0] == 32'd0));
      end
    end
    if (ov8 && or8) begin
      done8++;
      if (q8.size() == 0) chk("extra8", 32'(ov8), 32'd0);
      else begin
        e = q8.pop_front();
        chk("out8", 32'(o8), e[31:0]);
        chk("tag8", 32'(ot8), 32'(e[35:32]));
        chk("zero8", 32'(oz8), 32'(e[31:0] == 32'd0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    or32 = 1;
    or8 = 1;
    while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 32'(q32.size() + q8.size()), 32'd0);
  endtask

  // Latency counted in cycles from the accept cycle (cycle 1) to the first cycle showing out_valid.
  task automatic op32(input logic [31:0] d, input logic [4:0] l, input logic [1:0] m,
                      input logic [3:0] t, input logic [31:0] exp);
    int n;
    d32 = d; l32 = l; m32 = m; t32 = t; v32 = 1; or32 = 1;
    tick();
    chk("acc32", 32'(la32), 32'd1);
    v32 = 0;
    n = 1;
    while (!ov32 && n < 20) begin
      tick();
      n++;
    end
    chk("lat32", n, 32'd5);
    chk("res32", o32, exp);
    chk("rtag32", 32'(ot32), 32'(t));
    chk("rzero32", 32'(oz32), 32'(exp == 32'd0));
    tick();
  endtask

  task automatic op8(input logic [7:0] d, input logic [2:0] l, input logic [1:0] m,
                     input logic [3:0] t, input logic [7:0] exp);
    int n;
    d8 = d; l8 = l; m8 = m; t8 = t; v8 = 1; or8 = 1;
    tick();
    v8 = 0;
    n = 1;
    while (!ov8 && n < 20) begin
      tick();
      n++;
    end
    chk("lat8", n, 32'd3);
    chk("res8", 32'(o8), 32'(exp));
    tick();
  endtask

  task automatic rand32(input int nops);
    int tgt, c;
    tgt = acc32 + nops;
    c = 0;
    while (acc32 < tgt && c < 20000) begin
      if (!v32 || la32) begin
        v32 = ($urandom % 4) != 0;
        d32 = pick(32); l32 = 5'($urandom); m32 = 2'($urandom); t32 = 4'($urandom);
      end
      or32 = ($urandom % 4) != 0;
      tick();
      c++;
    end
    v32 = 0;
    drain();
    chk("rand32_ops", 32'(acc32 >= tgt), 32'd1);
    chk("count32", done32, acc32);
  endtask

  task automatic rand8(input int nops);
    int tgt, c;
    tgt = acc8 + nops;
    c = 0;
    while (acc8 < tgt && c < 20000) begin
      if (!v8 || la8) begin
        v8 = ($urandom % 4) != 0;
        d8 = 8'(pick(8)); l8 = 3'($urandom); m8 = 2'($urandom); t8 = 4'($urandom);
      end
      or8 = ($urandom % 4) != 0;
      tick();
      c++;
    end
    v8 = 0;
    drain();
    chk("rand8_ops", 32'(acc8 >= tgt), 32'd1);
    chk("count8", done8, acc8);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h;
    logic [3:0] ht;
    int base, seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ov32), 32'd0);
    chk("rst_out", o32, 32'd0);
    chk("rst_tag", 32'(ot32), 32'd0);
    chk("rst_zero", 32'(oz32), 32'd0);
    chk("rst_valid8", 32'(ov8), 32'd0);
    rst_n = 1;
    #1;
    chk("rst_ready", 32'(r32), 32'd1);
    tick();

    op32(32'h8000_0000, 5'd31, 2'b00, 4'd3, 32'h0000_0001);
    op32(32'hDEAD_BEEF, 5'd0, 2'b00, 4'd1, 32'hDEAD_BEEF);
    op32(32'h8000_0000, 5'd4, 2'b01, 4'd2, 32'hF800_0000);
    op32(32'h7FFF_FFFF, 5'd31, 2'b01, 4'd4, 32'h0000_0000);
    op32(32'h0000_0001, 5'd31, 2'b10, 4'd5, 32'h8000_0000);
    op32(32'h1234_5678, 5'd8, 2'b11, 4'd6, 32'h7812_3456);
    op32(32'h1234_5678, 5'd0, 2'b11, 4'd7, 32'h1234_5678);
    op8(8'h80, 3'd7, 2'b01, 4'd1, 8'hFF);
    op8(8'h81, 3'd1, 2'b11, 4'd2, 8'hC0);

    // Back-to-back tags 0..7 with a 3-cycle output stall once the pipe is full.
    base = done32;
    or32 = 1;
    for (int i = 0; i < 5; i++) begin
      d32 = $urandom; l32 = 5'($urandom); m32 = 2'($urandom); t32 = 4'(i); v32 = 1;
      tick();
    end
    chk("pipe_full", 32'(ov32), 32'd1);
    d32 = $urandom; l32 = 5'($urandom); m32 = 2'($urandom); t32 = 4'd5;
    or32 = 0;
    #1;
    h = o32;
    ht = ot32;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(r32), 32'd0);
      tick();
      chk("stall_out", o32, h);
      chk("stall_tag", 32'(ot32), 32'(ht));
      chk("stall_valid", 32'(ov32), 32'd1);
    end
    or32 = 1;
    for (int i = 5; i < 8; i++) begin
      if (i > 5) begin
        d32 = $urandom; l32 = 5'($urandom); m32 = 2'($urandom); t32 = 4'(i);
      end
      tick();
      chk("resume_acc", 32'(la32), 32'd1);
    end
    v32 = 0;
    drain();
    chk("b2b_count", done32 - base, 32'd8);

    rand32(5000);
    rand8(5000);

    // Reset with three operations in flight: they must vanish.
    for (int i = 0; i < 3; i++) begin
      d32 = 32'hA5A5_0000 | 32'(i); l32 = 5'(i + 1); m32 = 2'b11; t32 = 4'(9 + i); v32 = 1;
      tick();
    end
    v32 = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(ov32), 32'd0);
    chk("mid_rst_out", o32, 32'd0);
    chk("mid_rst_tag", 32'(ot32), 32'd0);
    chk("mid_rst_zero", 32'(oz32), 32'd0);
    acc32 -= q32.size();
    q32.delete();
    tick();
    rst_n = 1;
    seen = 0;
    repeat (8) begin
      tick();
      if (ov32) seen++;
    end
    chk("ghost_ops", seen, 32'd0);
    op32(32'h0F0F_0F0F, 5'd12, 2'b11, 4'd12, 32'hF0F0_F0F0);
    drain();
    chk("final_count32", done32, acc32);
    chk("final_count8", done8, acc8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
